// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encodings and handshake levels.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivIdle = 2'b00,
    DivBusy = 2'b01,
    DivDone = 2'b10
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, conditionally subtract.
module div_iter_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] part_o,
  output logic             qbit_o
);

  // The shifted partial needs one extra bit: part_i < divisor_i, so 2*part_i+1 can exceed WIDTH bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {part_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    part_o  = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for the EX stage: WIDTH cycles per divide, signed or unsigned,
// with divide-by-zero flag and annul; result is {remainder, quotient}.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               dz_o
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE) : v;
  endfunction

  // Most-negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return neg_if(v, is_signed && v[WIDTH-1]);
  endfunction

  div_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic             sign_q;
  logic             sign_r;

  logic             accept;
  logic             div_zero;
  logic             last_step;
  logic [WIDTH-1:0] step_part;
  logic             step_qbit;
  logic [WIDTH-1:0] quot_final;

  assign accept     = (state_q == DivIdle) && (start_i == DivStart) && !annul_i;
  assign div_zero   = (opdata2_i == '0);
  assign last_step  = (state_q == DivBusy) && !annul_i && (cnt_q == LAST_CNT);
  assign quot_final = {quot_q[WIDTH-2:0], step_qbit};

  div_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part_i   (rem_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .part_o   (step_part),
    .qbit_o   (step_qbit)
  );

  always_comb begin
    state_nxt = state_q;
    busy_o    = 1'b0;
    ready_o   = DivResultNotReady;
    case (state_q)
      DivIdle: begin
        if (accept) state_nxt = div_zero ? DivDone : DivBusy;
      end
      DivBusy: begin
        busy_o = 1'b1;
        if (annul_i)                 state_nxt = DivIdle;
        else if (cnt_q == LAST_CNT)  state_nxt = DivDone;
      end
      DivDone: begin
        ready_o   = DivResultReady;
        state_nxt = DivIdle;
      end
      default: state_nxt = DivIdle;
    endcase
  end

  // Control and visible outputs: reset clears everything, including a divide in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivIdle;
      cnt_q    <= '0;
      result_o <= '0;
      dz_o     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        cnt_q <= '0;
        if (div_zero) begin
          result_o <= '0;
          dz_o     <= 1'b1;
        end
      end else if (state_q == DivBusy) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (last_step) begin
        result_o <= {neg_if(step_part, sign_r), neg_if(quot_final, sign_q)};
        dz_o     <= 1'b0;
      end
    end
  end

  // Working datapath: loaded on accept, shifted one bit per DIV cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q  <= magnitude(opdata1_i, signed_div_i);
      dvs_q  <= magnitude(opdata2_i, signed_div_i);
      rem_q  <= '0;
      quot_q <= '0;
      sign_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      sign_r <= signed_div_i && opdata1_i[WIDTH-1];
    end else if (state_q == DivBusy) begin
      dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q  <= step_part;
      quot_q <= quot_final;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32) against a plain-arithmetic division model.
module tb_div_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         signed_div_i = 1'b0;
  logic [W-1:0] opdata1_i = '0;
  logic [W-1:0] opdata2_i = '0;
  logic         start_i = 1'b0;
  logic         annul_i = 1'b0;
  logic         busy_o, ready_o, dz_o;
  logic [2*W-1:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_res = '0;
  logic           last_dz  = 1'b0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .dz_o        (dz_o)
  );

  // Reference: C/MIPS truncating division computed in 64-bit arithmetic.
  function automatic logic [2*W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = a;
      sb = b;
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        output int lat, output int busy_cnt, output logic [2*W-1:0] res,
                        output logic dz, output logic seen);
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1; busy_cnt = 0; seen = 1'b0; res = 'x; dz = 1'bx;
    while (lat < 100) begin
      if (ready_o) begin
        seen = 1'b1; res = result_o; dz = dz_o;
        break;
      end
      if (busy_o) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    checks++; if (dz_o !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", dz_o); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat, bc; logic [2*W-1:0] res; logic dz, seen;
    run_op(32'd7, 32'd2, 1'b0, lat, bc, res, dz, seen);
    checks++; if (!seen) begin errors++; $display("FAIL u7_2_timeout: no ready within %0d cycles", lat); end
    checks++; if (lat != 33) begin errors++; $display("FAIL u7_2_latency: got %0d expected 33", lat); end
    checks++; if (bc != 32) begin errors++; $display("FAIL u7_2_busy_cycles: got %0d expected 32", bc); end
    checks++; if (res !== {32'h1, 32'h3}) begin errors++; $display("FAIL u7_2_result: got %h expected %h", res, {32'h1, 32'h3}); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL u7_2_dz: got %b expected 0", dz); end
    last_res = {32'h1, 32'h3}; last_dz = 1'b0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_pulse_width: got %b expected 0", ready_o); end
    checks++; if (result_o !== last_res) begin errors++; $display("FAIL result_hold: got %h expected %h", result_o, last_res); end
  endtask

  task automatic test_signed();
    int lat, bc; logic [2*W-1:0] res, exp; logic dz, seen;
    run_op(32'hFFFFFFF9, 32'h2, 1'b1, lat, bc, res, dz, seen);
    exp = model_res(32'hFFFFFFF9, 32'h2, 1'b1);
    checks++; if (res !== exp) begin errors++; $display("FAIL s_m7_2_result: got %h expected %h", res, exp); end
    checks++; if (lat != 33) begin errors++; $display("FAIL s_m7_2_latency: got %0d expected 33", lat); end
    run_op(32'h7, 32'hFFFFFFFE, 1'b1, lat, bc, res, dz, seen);
    exp = model_res(32'h7, 32'hFFFFFFFE, 1'b1);
    checks++; if (res !== exp) begin errors++; $display("FAIL s_7_m2_result: got %h expected %h", res, exp); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL s_7_m2_dz: got %b expected 0", dz); end
    last_res = exp; last_dz = 1'b0;
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [2*W-1:0] res, exp; logic dz, seen;
    run_op(32'h1234, 32'h0, 1'b0, lat, bc, res, dz, seen);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (bc != 0) begin errors++; $display("FAIL dz_busy_cycles: got %0d expected 0", bc); end
    checks++; if (res !== '0) begin errors++; $display("FAIL dz_result: got %h expected 0", res); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz); end
    run_op(32'd10, 32'd3, 1'b0, lat, bc, res, dz, seen);
    exp = model_res(32'd10, 32'd3, 1'b0);
    checks++; if (res !== exp) begin errors++; $display("FAIL after_dz_result: got %h expected %h", res, exp); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL after_dz_flag: got %b expected 0", dz); end
    last_res = exp; last_dz = 1'b0;
  endtask

  task automatic test_overflow();
    int lat, bc; logic [2*W-1:0] res; logic dz, seen;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bc, res, dz, seen);
    checks++; if (res !== {32'h0, 32'h80000000}) begin errors++; $display("FAIL s_overflow_result: got %h expected %h", res, {32'h0, 32'h80000000}); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL s_overflow_dz: got %b expected 0", dz); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc, res, dz, seen);
    checks++; if (res !== {32'h80000000, 32'h0}) begin errors++; $display("FAIL u_big_result: got %h expected %h", res, {32'h80000000, 32'h0}); end
    last_res = {32'h80000000, 32'h0}; last_dz = 1'b0;
  endtask

  task automatic test_annul();
    int lat, bc, rdy_seen; logic [2*W-1:0] res, exp; logic dz, seen;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk); annul_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL annul_idle: busy got %b expected 0", busy_o); end
    rdy_seen = 0;
    repeat (40) begin
      if (ready_o) rdy_seen++;
      @(negedge clk);
    end
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL annul_no_ready: got %0d pulses expected 0", rdy_seen); end
    checks++; if (result_o !== last_res) begin errors++; $display("FAIL annul_result_hold: got %h expected %h", result_o, last_res); end
    run_op(32'd100, 32'd7, 1'b0, lat, bc, res, dz, seen);
    exp = model_res(32'd100, 32'd7, 1'b0);
    checks++; if (res !== exp) begin errors++; $display("FAIL post_annul_result: got %h expected %h", res, exp); end
    checks++; if (lat != 33) begin errors++; $display("FAIL post_annul_latency: got %0d expected 33", lat); end
    last_res = exp; last_dz = 1'b0;
  endtask

  task automatic test_start_annul();
    int act;
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd0; signed_div_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
    act = 0;
    repeat (5) begin
      if (busy_o || ready_o) act++;
      @(negedge clk);
    end
    checks++; if (act != 0) begin errors++; $display("FAIL start_annul_accepted: got %0d active cycles expected 0", act); end
    checks++; if (dz_o !== last_dz) begin errors++; $display("FAIL start_annul_dz: got %b expected %b", dz_o, last_dz); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [2*W-1:0] res, exp; logic dz, seen;
    @(negedge clk);
    opdata1_i = 32'd999; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd0; signed_div_i = 1'b1;
    repeat (4) @(negedge clk);
    start_i = 1'b0;
    lat = 0;
    while (!ready_o && lat < 100) begin @(negedge clk); lat++; end
    exp = model_res(32'd999, 32'd10, 1'b0);
    checks++; if (result_o !== exp) begin errors++; $display("FAIL start_ignored_result: got %h expected %h", result_o, exp); end
    run_op(32'hFFFFFFF0, 32'd3, 1'b1, lat, bc, res, dz, seen);
    exp = model_res(32'hFFFFFFF0, 32'd3, 1'b1);
    checks++; if (res !== exp) begin errors++; $display("FAIL b2b_result: got %h expected %h", res, exp); end
    last_res = exp; last_dz = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat, bc; logic [2*W-1:0] res; logic dz, seen;
    @(negedge clk);
    opdata1_i = 32'd123456; opdata2_i = 32'd11; signed_div_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL arst_result: got %h expected 0", result_o); end
    checks++; if (dz_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL arst_flags: got dz=%b ready=%b expected 0", dz_o, ready_o); end
    @(negedge clk); rst = 1'b1;
    run_op(32'hFFFFFFFF, 32'h10, 1'b0, lat, bc, res, dz, seen);
    checks++; if (res !== {32'hF, 32'h0FFFFFFF}) begin errors++; $display("FAIL arst_after_result: got %h expected %h", res, {32'hF, 32'h0FFFFFFF}); end
    checks++; if (lat != 33) begin errors++; $display("FAIL arst_after_latency: got %0d expected 33", lat); end
    last_res = {32'hF, 32'h0FFFFFFF}; last_dz = 1'b0;
  endtask

  task automatic test_random();
    int lat, bc; logic [2*W-1:0] res, exp; logic dz, seen, sgn;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: b = -$urandom_range(1, 9);
        default: b = $urandom;
      endcase
      sgn = $urandom_range(0, 1);
      run_op(a, b, sgn, lat, bc, res, dz, seen);
      exp = model_res(a, b, sgn);
      checks++; if (!seen || res !== exp) begin errors++; $display("FAIL rand_result[%0d] %h/%h s=%b: got %h expected %h", i, a, b, sgn, res, exp); end
      checks++; if (dz !== (b == '0)) begin errors++; $display("FAIL rand_dz[%0d]: got %b expected %b", i, dz, (b == '0)); end
      checks++; if (lat != ((b == '0) ? 1 : 33)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, (b == '0) ? 1 : 33); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_start_annul();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
